apb_led_sw_ctrl: RTL and testbench
==================================

# apb_led_sw_ctrl

APB3 slave peripheral that drives a parametrised bank of LEDs and samples a parametrised bank of switch inputs. It replaces the fixed GPIO-to-LED/switch wiring at board top level and attaches to the SoC's `io_apbSlave_0` port. Each LED supports off, on, PWM brightness and blink modes. Each switch is synchronised and debounced, with per-switch edge interrupt.

## Interface
Parameters:
- `LED_NUM`, 8: LED channel count, 1..16.
- `SW_NUM`, 1: switch channel count, 1..16.
- `PWM_BITS`, 8: PWM counter and duty width, 4..16.
- `DEBOUNCE_CNT`, 50000: cycles an input must be stable before it is accepted; ≥2.
- `BLINK_DEFAULT`, 24'd5_000_000: reset value of BLINK_DIV.

Ports (clock and reset first):
- `io_systemClk` in 1: sole clock.
- `io_systemReset` in 1: synchronous, active-high reset.
- `io_apbSlave_0_PADDR` in 16: byte address.
- `io_apbSlave_0_PSEL` in 1: APB select.
- `io_apbSlave_0_PENABLE` in 1: APB access phase.
- `io_apbSlave_0_PWRITE` in 1: 1 = write.
- `io_apbSlave_0_PWDATA` in 32: write data.
- `io_apbSlave_0_PRDATA` out 32: read data.
- `io_apbSlave_0_PREADY` out 1: tied to 1.
- `io_apbSlave_0_PSLVERROR` out 1: error for unmapped address.
- `o_led` out LED_NUM: LED drive, active-high.
- `i_sw` in SW_NUM: asynchronous switch inputs.
- `o_irq` out 1: level interrupt.

## Operation
Register map (word-aligned, PADDR[1:0] ignored):
- 0x00 ID (RO): {16'h4C53, SW_NUM[7:0], LED_NUM[7:0]}.
- 0x04 MODE (RW): 2 bits per LED, LED i at [2i+1:2i]. 00 off, 01 on, 10 PWM, 11 blink.
- 0x08 BLINK_DIV (RW, [23:0]): half-period of blink in cycles, minus 1.
- 0x0C SW_STATE (RO): debounced switch levels.
- 0x10 IRQ_STATUS (RW1C): bit i set on any edge of debounced switch i.
- 0x14 IRQ_EN (RW): per-switch enable.
- 0x40 + 4i DUTY[i] (RW, [PWM_BITS-1:0]): one register per LED, i < LED_NUM.

Behaviour:
- APB: zero wait states.
  - Writes commit on the cycle where PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR; unimplemented bits read 0.
  - PSLVERROR=1 during the access phase to any address outside the map, including DUTY[i] with i ≥ LED_NUM. Such writes are ignored.
- PWM: a free-running PWM_BITS counter `pcnt`. A PWM LED is on when pcnt < DUTY[i]. DUTY=0 is always off; max DUTY is on for (2^PWM_BITS−1)/2^PWM_BITS of the period.
- Blink: a 24-bit prescaler counts 0..BLINK_DIV, then wraps and toggles `phase`. Blink LEDs show `phase`.
  - Writing BLINK_DIV restarts the prescaler at 0 and leaves `phase` unchanged.
  - BLINK_DIV=0 toggles every cycle.
- Debounce, per switch:
  - 2-flop synchroniser, then counter `dcnt`.
  - If sync ≠ stable, increment dcnt. On dcnt = DEBOUNCE_CNT−1, set stable=sync and clear dcnt.
  - If sync = stable, clear dcnt, so a glitch restarts the count.
- IRQ: when stable changes, the IRQ_STATUS bit is set. If an edge and a W1C of the same bit occur in the same cycle, set wins. o_irq = |(IRQ_STATUS & IRQ_EN), registered.

## Timing
- Reset values:
  - o_led=0, PRDATA reflects reset registers, PSLVERROR=0, o_irq=0.
  - MODE=0, DUTY=0, IRQ_EN=0, IRQ_STATUS=0.
  - BLINK_DIV=BLINK_DEFAULT, pcnt=0, prescaler=0, phase=0.
  - stable=0, dcnt=0, synchroniser flops=0.
- o_led is registered: a MODE/DUTY write is visible on o_led 1 cycle after the write cycle.
- Switch to SW_STATE: 2 sync cycles + DEBOUNCE_CNT cycles. IRQ_STATUS sets in the same cycle stable updates; o_irq follows 1 cycle later.
- A switch held high through reset produces a rising edge and a status set once debounce completes after reset release.
- Reset asserted mid-operation clears all state in the next cycle, including partially counted dcnt and pending IRQ.
- pcnt wraps from 2^PWM_BITS−1 to 0 with no gap; the prescaler wraps from BLINK_DIV to 0.

## Structure
- Package `apb_led_sw_pkg`:
  - register offset localparams (ID, MODE, BLINK_DIV, SW_STATE, IRQ_STATUS, IRQ_EN, DUTY_BASE);
  - LED mode encoding constants;
  - ID magic 16'h4C53.
- Sub-module `sw_debounce` (one switch: synchroniser, counter, stable output, edge pulse), instantiated SW_NUM times via generate.
- The APB decode, PWM counter, prescaler and LED mux live in the top module.

## Test plan
- Reset, then read ID with LED_NUM=8, SW_NUM=1 -> PRDATA=0x4C530108. o_led=0, o_irq=0, PSLVERROR=0.
- Write MODE=0x0001 -> o_led=0x01 exactly 1 cycle after the write. Read 0x20 -> PSLVERROR=1, PRDATA=0.
- PWM_BITS=8, MODE[1:0]=10, DUTY[0]=64 -> LED0 high for exactly 64 of every 256 cycles. DUTY[0]=0 -> never high.
- BLINK_DIV=9, MODE[1:0]=11 -> LED0 toggles every 10 cycles. Rewriting BLINK_DIV mid-period restarts the count from 0.
- DEBOUNCE_CNT=8, IRQ_EN=1:
  - pulse i_sw high for 5 cycles -> SW_STATE stays 0, no IRQ;
  - hold high -> SW_STATE=1 after 2+8 cycles, o_irq=1 one cycle later;
  - W1C 0x10 -> o_irq=0 next cycle.
- W1C of IRQ_STATUS bit 0 in the same cycle as a new debounced edge -> bit remains 1 and o_irq stays 1.

Source files
------------

// File: rtl/apb_led_sw_pkg.sv
// Shared constants for the APB LED/switch controller: register offsets,
// LED mode encodings and the identification magic number.
package apb_led_sw_pkg;

  localparam logic [15:0] REG_ID         = 16'h0000;
  localparam logic [15:0] REG_MODE       = 16'h0004;
  localparam logic [15:0] REG_BLINK_DIV  = 16'h0008;
  localparam logic [15:0] REG_SW_STATE   = 16'h000C;
  localparam logic [15:0] REG_IRQ_STATUS = 16'h0010;
  localparam logic [15:0] REG_IRQ_EN     = 16'h0014;
  localparam logic [15:0] REG_DUTY_BASE  = 16'h0040;

  localparam logic [1:0] LED_MODE_OFF   = 2'b00;
  localparam logic [1:0] LED_MODE_ON    = 2'b01;
  localparam logic [1:0] LED_MODE_PWM   = 2'b10;
  localparam logic [1:0] LED_MODE_BLINK = 2'b11;

  localparam logic [15:0] ID_MAGIC = 16'h4C53;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchroniser followed by a stability counter.
// The accepted level only changes after the synchronised input has differed
// from it for DEBOUNCE_CNT consecutive cycles; sw_edge pulses in the cycle
// the accepted level is about to change.
module sw_debounce
  import apb_led_sw_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_async,
  output logic sw_stable,
  output logic sw_edge
);

  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CNT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [DW-1:0] dcnt;

  assign sw_edge = (sync_q2 != sw_stable) && (dcnt == DCNT_LAST);

  // Synchronise the raw input and accept it once it has held long enough;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sw_stable <= 1'b0;
      dcnt      <= '0;
    end else begin
      sync_q1 <= sw_async;
      sync_q2 <= sync_q1;
      if (sync_q2 == sw_stable) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        sw_stable <= sync_q2;
        dcnt      <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_led_sw_ctrl.sv
// APB3 peripheral driving a bank of LEDs (off/on/PWM/blink per channel) and
// sampling a bank of debounced switches with per-switch edge interrupts.
module apb_led_sw_ctrl
  import apb_led_sw_pkg::*;
#(
  parameter int          LED_NUM       = 8,
  parameter int          SW_NUM        = 1,
  parameter int          PWM_BITS      = 8,
  parameter int          DEBOUNCE_CNT  = 50000,
  parameter logic [23:0] BLINK_DEFAULT = 24'd5_000_000
) (
  input  logic               io_systemClk,
  input  logic               io_systemReset,
  input  logic [15:0]        io_apbSlave_0_PADDR,
  input  logic               io_apbSlave_0_PSEL,
  input  logic               io_apbSlave_0_PENABLE,
  input  logic               io_apbSlave_0_PWRITE,
  input  logic [31:0]        io_apbSlave_0_PWDATA,
  output logic [31:0]        io_apbSlave_0_PRDATA,
  output logic               io_apbSlave_0_PREADY,
  output logic               io_apbSlave_0_PSLVERROR,
  output logic [LED_NUM-1:0] o_led,
  input  logic [SW_NUM-1:0]  i_sw,
  output logic               o_irq
);

  logic [15:0]           reg_addr;
  logic                  access;
  logic                  wr_en;
  logic                  addr_hit;
  logic [31:0]           rdata;
  logic [LED_NUM-1:0]    duty_hit;
  logic [2*LED_NUM-1:0]  mode;
  logic [23:0]           blink_div;
  logic [PWM_BITS-1:0]   duty [LED_NUM];
  logic [SW_NUM-1:0]     sw_stable;
  logic [SW_NUM-1:0]     sw_edge;
  logic [SW_NUM-1:0]     irq_status;
  logic [SW_NUM-1:0]     irq_en;
  logic [SW_NUM-1:0]     w1c_mask;
  logic [PWM_BITS-1:0]   pcnt;
  logic [23:0]           prescaler;
  logic                  phase;
  logic [LED_NUM-1:0]    led_next;
  logic                  unused_apb;

  assign reg_addr   = {io_apbSlave_0_PADDR[15:2], 2'b00};
  assign access     = io_apbSlave_0_PSEL & io_apbSlave_0_PENABLE;
  assign wr_en      = access & io_apbSlave_0_PWRITE;
  assign unused_apb = ^{io_apbSlave_0_PADDR[1:0], io_apbSlave_0_PWDATA};

  assign io_apbSlave_0_PREADY    = 1'b1;
  assign io_apbSlave_0_PSLVERROR = access & ~addr_hit;
  assign io_apbSlave_0_PRDATA    = rdata;

  assign w1c_mask = (wr_en && reg_addr == REG_IRQ_STATUS) ?
                    io_apbSlave_0_PWDATA[SW_NUM-1:0] : '0;

  // One debouncer per switch input.
  for (genvar g = 0; g < SW_NUM; g++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
      .clk       (io_systemClk),
      .reset     (io_systemReset),
      .sw_async  (i_sw[g]),
      .sw_stable (sw_stable[g]),
      .sw_edge   (sw_edge[g])
    );
  end

  // Flag which implemented DUTY register, if any, the address selects.
  always_comb begin
    for (int i = 0; i < LED_NUM; i++) begin
      duty_hit[i] = (reg_addr == REG_DUTY_BASE + 16'(4 * i));
    end
  end

  // Combinational read mux; also decides whether the address is mapped.
  always_comb begin
    rdata    = '0;
    addr_hit = 1'b1;
    case (reg_addr)
      REG_ID:         rdata = {ID_MAGIC, 8'(SW_NUM), 8'(LED_NUM)};
      REG_MODE:       rdata = 32'(mode);
      REG_BLINK_DIV:  rdata = 32'(blink_div);
      REG_SW_STATE:   rdata = 32'(sw_stable);
      REG_IRQ_STATUS: rdata = 32'(irq_status);
      REG_IRQ_EN:     rdata = 32'(irq_en);
      default: begin
        addr_hit = |duty_hit;
        for (int i = 0; i < LED_NUM; i++) begin
          if (duty_hit[i]) rdata = 32'(duty[i]);
        end
      end
    endcase
  end

  // Writable configuration registers; unmapped and read-only writes drop.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      mode      <= '0;
      blink_div <= BLINK_DEFAULT;
      irq_en    <= '0;
      for (int i = 0; i < LED_NUM; i++) duty[i] <= '0;
    end else if (wr_en) begin
      case (reg_addr)
        REG_MODE:      mode      <= io_apbSlave_0_PWDATA[2*LED_NUM-1:0];
        REG_BLINK_DIV: blink_div <= io_apbSlave_0_PWDATA[23:0];
        REG_IRQ_EN:    irq_en    <= io_apbSlave_0_PWDATA[SW_NUM-1:0];
        default: begin
          for (int i = 0; i < LED_NUM; i++) begin
            if (duty_hit[i]) duty[i] <= io_apbSlave_0_PWDATA[PWM_BITS-1:0];
          end
        end
      endcase
    end
  end

  // Sticky edge status; a new edge beats a simultaneous write-one-to-clear.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) irq_status <= '0;
    else                irq_status <= (irq_status & ~w1c_mask) | sw_edge;
  end

  // Registered interrupt level from enabled pending bits.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) o_irq <= 1'b0;
    else                o_irq <= |(irq_status & irq_en);
  end

  // Free-running PWM counter shared by all LEDs.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) pcnt <= '0;
    else                pcnt <= pcnt + 1'b1;
  end

  // Blink prescaler; a BLINK_DIV write restarts the period without
  // disturbing the current phase.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      prescaler <= '0;
      phase     <= 1'b0;
    end else if (wr_en && reg_addr == REG_BLINK_DIV) begin
      prescaler <= '0;
    end else if (prescaler == blink_div) begin
      prescaler <= '0;
      phase     <= ~phase;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Per-LED source selection by mode.
  always_comb begin
    for (int i = 0; i < LED_NUM; i++) begin
      led_next[i] = 1'b0;
      case (mode[2*i +: 2])
        LED_MODE_OFF:   led_next[i] = 1'b0;
        LED_MODE_ON:    led_next[i] = 1'b1;
        LED_MODE_PWM:   led_next[i] = (pcnt < duty[i]);
        LED_MODE_BLINK: led_next[i] = phase;
      endcase
    end
  end

  // Glitch-free registered LED drive.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) o_led <= '0;
    else                o_led <= led_next;
  end

endmodule

// File: tb/tb_apb_led_sw_ctrl.sv
// Scoreboard bench for apb_led_sw_ctrl: stimulus pushes expected APB
// responses and a cycle reference model pushes expected LED/IRQ levels;
// a separate monitor pops and compares.
module tb_apb_led_sw_ctrl;

  localparam int LED_NUM   = 8;
  localparam int SW_NUM    = 1;
  localparam int PWM_BITS  = 8;
  localparam int DEB       = 8;
  localparam int BLINK_DEF = 5000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  o_led;
  logic [0:0]  i_sw;
  logic        o_irq;

  always #5 clk = ~clk;

  apb_led_sw_ctrl #(
    .LED_NUM(LED_NUM), .SW_NUM(SW_NUM), .PWM_BITS(PWM_BITS),
    .DEBOUNCE_CNT(DEB), .BLINK_DEFAULT(24'd5_000_000)
  ) dut (
    .io_systemClk            (clk),
    .io_systemReset          (rst),
    .io_apbSlave_0_PADDR     (paddr),
    .io_apbSlave_0_PSEL      (psel),
    .io_apbSlave_0_PENABLE   (penable),
    .io_apbSlave_0_PWRITE    (pwrite),
    .io_apbSlave_0_PWDATA    (pwdata),
    .io_apbSlave_0_PRDATA    (prdata),
    .io_apbSlave_0_PREADY    (pready),
    .io_apbSlave_0_PSLVERROR (pslverr),
    .o_led                   (o_led),
    .i_sw                    (i_sw),
    .o_irq                   (o_irq)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } apb_exp_t;

  typedef struct {
    logic [7:0] led;
    logic       irq;
  } out_exp_t;

  apb_exp_t apb_q[$];
  out_exp_t out_q[$];

  // Reference model state, expressed as elapsed-cycle arithmetic.
  int          n;
  logic [15:0] m_mode;
  int          m_div;
  int          m_bs;
  bit          m_base;
  int          m_duty[LED_NUM];
  bit          m_stable, m_status, m_en;
  bit          hist[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic bit blink_phase(input int cnt);
    int q;
    q = (cnt - m_bs) / (m_div + 1);
    return m_base ^ q[0];
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    logic [15:0] w;
    w = a & 16'hFFFC;
    if (w inside {16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014})
      return 1'b1;
    return (w >= 16'h0040) && (w < 16'h0040 + 16'(4 * LED_NUM));
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [15:0] w;
    w = a & 16'hFFFC;
    case (w)
      16'h0000: return 32'h4C530108;
      16'h0004: return {16'h0, m_mode};
      16'h0008: return 32'(m_div);
      16'h000C: return {31'b0, m_stable};
      16'h0010: return {31'b0, m_status};
      16'h0014: return {31'b0, m_en};
      default: begin
        if (w >= 16'h0040 && w < 16'h0060) return 32'(m_duty[int'((w - 16'h40) >> 2)]);
        return 32'h0;
      end
    endcase
  endfunction

  // Reference model: at each edge publish the outputs the DUT should show
  // after this edge, then advance the model by the inputs seen at the edge.
  always @(posedge clk) begin
    out_exp_t    e;
    bit          flip;
    logic        wr;
    logic [15:0] w;
    bit          w1c;
    if (rst) begin
      n = 0; m_mode = 0; m_div = BLINK_DEF; m_bs = 0; m_base = 0;
      m_stable = 0; m_status = 0; m_en = 0;
      for (int i = 0; i < LED_NUM; i++) m_duty[i] = 0;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
      e.led = 8'h00; e.irq = 1'b0;
      out_q.push_back(e);
    end else begin
      for (int i = 0; i < LED_NUM; i++) begin
        case (m_mode[2*i +: 2])
          2'b00: e.led[i] = 1'b0;
          2'b01: e.led[i] = 1'b1;
          2'b10: e.led[i] = ((n % 256) < m_duty[i]);
          default: e.led[i] = blink_phase(n);
        endcase
      end
      e.irq = m_status & m_en;
      out_q.push_back(e);
      // accepted level flips once the input seen two edges ago and the
      // DEB-1 before it all disagree with it
      hist.push_back(i_sw[0]);
      flip = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[hist.size() - 3 - j] == m_stable) flip = 1'b0;
      while (hist.size() > DEB + 4) void'(hist.pop_front());
      wr  = psel && penable && pwrite;
      w   = paddr & 16'hFFFC;
      w1c = wr && (w == 16'h0010) && pwdata[0];
      if (flip) m_stable = ~m_stable;
      if (wr && w == 16'h0008) begin
        m_base = blink_phase(n);
        m_bs   = n + 1;
        m_div  = int'(pwdata[23:0]);
      end
      if (wr && w == 16'h0004) m_mode = pwdata[15:0];
      if (wr && w == 16'h0014) m_en = pwdata[0];
      if (wr && w >= 16'h0040 && w < 16'h0060)
        m_duty[int'((w - 16'h40) >> 2)] = int'(pwdata[7:0]);
      m_status = (m_status & ~w1c) | flip;
      n++;
    end
  end

  // Monitor: compare APB responses in the access phase and LED/IRQ levels
  // every cycle, away from the active edge.
  always @(negedge clk) begin
    apb_exp_t x;
    out_exp_t o;
    #2;
    if (psel && penable) begin
      if (apb_q.size() == 0) begin
        checkOutput("apb_queue_entries", 0, 1);
      end else begin
        x = apb_q.pop_front();
        checkOutput("pslverr", 32'(pslverr), 32'(x.err));
        checkOutput("pready", 32'(pready), 1);
        if (x.is_read) checkOutput("prdata", prdata, x.rdata);
      end
    end else begin
      checkOutput("pslverr_idle", 32'(pslverr), 0);
    end
    if (out_q.size() > 0) begin
      o = out_q.pop_front();
      checkOutput("o_led", 32'(o_led), 32'(o.led));
      checkOutput("o_irq", 32'(o_irq), 32'(o.irq));
    end
  end

  task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                               input logic [31:0] data);
    apb_exp_t x;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1;
    x.addr    = addr;
    x.is_read = !wr;
    x.err     = !is_mapped(addr);
    x.rdata   = is_mapped(addr) ? model_read(addr) : 32'h0;
    apb_q.push_back(x);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cnt;
    logic        prev;
    logic [15:0] addr;
    logic [31:0] data;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    i_sw = 1'b0; rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // identification and reset levels
    applyStimulus(1'b0, 16'h0000, 0);
    checkOutput("reset_o_led", 32'(o_led), 0);
    checkOutput("reset_o_irq", 32'(o_irq), 0);

    // static on, one cycle after commit
    applyStimulus(1'b1, 16'h0004, 32'h1);
    checkOutput("led_on_before", 32'(o_led), 0);
    @(negedge clk);
    checkOutput("led_on_after", 32'(o_led), 1);
    applyStimulus(1'b0, 16'h0020, 0);

    // PWM duty 64 of 256, then 0
    applyStimulus(1'b1, 16'h0040, 64);
    applyStimulus(1'b1, 16'h0004, 32'h2);
    idle(2);
    cnt = 0;
    repeat (256) begin @(negedge clk); #3; cnt += int'(o_led[0]); end
    checkOutput("pwm_duty64_high", cnt, 64);
    applyStimulus(1'b1, 16'h0040, 0);
    idle(2);
    cnt = 0;
    repeat (256) begin @(negedge clk); #3; cnt += int'(o_led[0]); end
    checkOutput("pwm_duty0_high", cnt, 0);

    // blink every 10 cycles, then a mid-period restart
    applyStimulus(1'b1, 16'h0008, 9);
    applyStimulus(1'b1, 16'h0004, 32'h3);
    idle(3);
    #3; prev = o_led[0]; cnt = 0;
    repeat (100) begin
      @(negedge clk); #3;
      if (o_led[0] !== prev) cnt++;
      prev = o_led[0];
    end
    checkOutput("blink_toggles", cnt, 10);
    idle(4);
    applyStimulus(1'b1, 16'h0008, 9);
    idle(30);

    // debounce: short glitch rejected
    applyStimulus(1'b1, 16'h0014, 1);
    @(negedge clk); i_sw = 1'b1;
    idle(5); i_sw = 1'b0;
    idle(20);
    applyStimulus(1'b0, 16'h000C, 0);
    checkOutput("glitch_irq", 32'(o_irq), 0);

    // held input accepted after 2+DEB cycles, irq one cycle later
    @(negedge clk); i_sw = 1'b1;
    idle(10);
    checkOutput("irq_before_set", 32'(o_irq), 0);
    @(negedge clk);
    checkOutput("irq_set", 32'(o_irq), 1);
    applyStimulus(1'b0, 16'h000C, 0);
    applyStimulus(1'b1, 16'h0010, 1);
    @(negedge clk);
    checkOutput("irq_cleared", 32'(o_irq), 0);

    // falling edge pends status; then a new edge coincides with W1C
    @(negedge clk); i_sw = 1'b0;
    idle(15);
    @(negedge clk); i_sw = 1'b1;
    idle(7);
    applyStimulus(1'b1, 16'h0010, 1);
    idle(2);
    checkOutput("simul_edge_irq", 32'(o_irq), 1);
    applyStimulus(1'b0, 16'h0010, 0);

    // randomized register traffic and switch activity
    repeat (200) begin
      if ($urandom_range(0, 2) == 0) i_sw[0] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: addr = 16'(4 * $urandom_range(0, 7));
        1: addr = 16'h0040 + 16'(4 * $urandom_range(0, 15));
        2: addr = 16'($urandom);
        default: addr = 16'(4 * $urandom_range(0, 5));
      endcase
      addr = addr | 16'($urandom_range(0, 3));
      data = $urandom;
      if ((addr & 16'hFFFC) == 16'h0008) data = $urandom_range(0, 20);
      applyStimulus(1'($urandom_range(0, 1)), addr, data);
      idle($urandom_range(0, 6));
    end

    // reset mid-operation with the switch held high through it
    applyStimulus(1'b1, 16'h0014, 1);
    applyStimulus(1'b1, 16'h0004, 32'h5555);
    @(negedge clk); i_sw = 1'b1;
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_led", 32'(o_led), 0);
    checkOutput("mid_reset_irq", 32'(o_irq), 0);
    idle(1);
    rst = 1'b0;
    idle(15);
    applyStimulus(1'b0, 16'h0010, 0);
    applyStimulus(1'b0, 16'h000C, 0);
    applyStimulus(1'b0, 16'h0008, 0);
    applyStimulus(1'b0, 16'h0000, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
